// File: rtl/regfile_pkg.sv
// Shared types and packed-slice index helpers for the LVT register file read side.
package regfile_pkg;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bank-select type for the default four-bank configuration.
   localparam int unsigned DEF_WRITE_PORTS = 4;
   localparam int unsigned DEF_SEL_WIDTH   = clog2_min1(DEF_WRITE_PORTS);
   typedef logic [DEF_SEL_WIDTH-1:0] sel_t;

   function automatic int unsigned addr_lsb(input int unsigned port, input int unsigned aw);
      return port * aw;
   endfunction

   function automatic int unsigned data_lsb(input int unsigned port, input int unsigned dw);
      return port * dw;
   endfunction

   function automatic int unsigned bank_lsb(input int unsigned rd_port, input int unsigned bank,
                                            input int unsigned write_ports, input int unsigned dw);
      return (rd_port * write_ports + bank) * dw;
   endfunction

endpackage

// File: rtl/regfile_lvt.sv
// Live value table: remembers which write port last wrote each register,
// with highest-port-wins priority and same-address write collision detection.
module regfile_lvt
   import regfile_pkg::*;
#(
   parameter int unsigned REG_COUNT   = 256,
   parameter int unsigned ADDR_WIDTH  = $clog2(REG_COUNT),
   parameter int unsigned WRITE_PORTS = 4,
   parameter int unsigned READ_PORTS  = 8,
   parameter int unsigned SEL_WIDTH   = clog2_min1(WRITE_PORTS)
) (
   input  logic                              clk,
   input  logic                              sync_rst,
   input  logic                              clk_en,
   input  logic [WRITE_PORTS-1:0]            wr_en,
   input  logic [ADDR_WIDTH*WRITE_PORTS-1:0] wr_addr,
   input  logic [ADDR_WIDTH*READ_PORTS-1:0]  rd_addr,
   output logic [SEL_WIDTH*READ_PORTS-1:0]   rd_sel,
   output logic                              wr_conflict
);

   logic [SEL_WIDTH-1:0] r_lvt [REG_COUNT];
   logic                 r_conflict;
   logic                 w_conflict;

   always_comb begin
      w_conflict = 1'b0;
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
         for (int unsigned q = p + 1; q < WRITE_PORTS; q++) begin
            if (wr_en[p] && wr_en[q] &&
                (wr_addr[addr_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH] ==
                 wr_addr[addr_lsb(q, ADDR_WIDTH) +: ADDR_WIDTH])) begin
               w_conflict = 1'b1;
            end
         end
      end
   end

   // Ascending loop: the last non-blocking write to an entry wins, so the highest port has priority.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            r_lvt[i] <= '0;
         end
         r_conflict <= 1'b0;
      end else if (clk_en) begin
         for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            if (wr_en[p]) begin
               r_lvt[wr_addr[addr_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH]] <= SEL_WIDTH'(p);
            end
         end
         r_conflict <= w_conflict;
      end
   end

   always_comb begin
      rd_sel = '0;
      for (int unsigned r = 0; r < READ_PORTS; r++) begin
         rd_sel[r*SEL_WIDTH +: SEL_WIDTH] = r_lvt[rd_addr[addr_lsb(r, ADDR_WIDTH) +: ADDR_WIDTH]];
      end
   end

   assign wr_conflict = r_conflict;

endmodule

// File: rtl/regfile_lvt_read_port.sv
// Read side of the multi-bank register file: LVT bank select, write-first
// forwarding and a one-cycle read pipeline per read port.
module regfile_lvt_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned REG_COUNT   = 256,
   parameter int unsigned ADDR_WIDTH  = $clog2(REG_COUNT),
   parameter int unsigned WRITE_PORTS = 4,
   parameter int unsigned READ_PORTS  = 8,
   parameter int unsigned SEL_WIDTH   = clog2_min1(WRITE_PORTS)
) (
   input  logic                                         clk,
   input  logic                                         sync_rst,
   input  logic                                         clk_en,
   input  logic [WRITE_PORTS-1:0]                       wr_en,
   input  logic [ADDR_WIDTH*WRITE_PORTS-1:0]            wr_addr,
   input  logic [DATA_WIDTH*WRITE_PORTS-1:0]            wr_data,
   input  logic [READ_PORTS-1:0]                        rd_en,
   input  logic [ADDR_WIDTH*READ_PORTS-1:0]             rd_addr,
   input  logic [DATA_WIDTH*WRITE_PORTS*READ_PORTS-1:0] bank_rd_data,
   output logic [DATA_WIDTH*READ_PORTS-1:0]             rd_data,
   output logic [READ_PORTS-1:0]                        rd_valid,
   output logic                                         wr_conflict
);

   logic [SEL_WIDTH*READ_PORTS-1:0] w_lookup;
   logic [READ_PORTS-1:0]           w_fwd_hit;
   logic [DATA_WIDTH-1:0]           w_fwd_data [READ_PORTS];
   logic [DATA_WIDTH-1:0]           w_rd_mux   [READ_PORTS];

   logic [SEL_WIDTH-1:0]            r_sel      [READ_PORTS];
   logic [READ_PORTS-1:0]           r_fwd_hit;
   logic [DATA_WIDTH-1:0]           r_fwd_data [READ_PORTS];
   logic [DATA_WIDTH-1:0]           r_hold     [READ_PORTS];
   logic [READ_PORTS-1:0]           r_rd_valid;

   regfile_lvt #(
      .REG_COUNT   (REG_COUNT),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WRITE_PORTS (WRITE_PORTS),
      .READ_PORTS  (READ_PORTS),
      .SEL_WIDTH   (SEL_WIDTH)
   ) u_lvt (
      .clk         (clk),
      .sync_rst    (sync_rst),
      .clk_en      (clk_en),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .rd_addr     (rd_addr),
      .rd_sel      (w_lookup),
      .wr_conflict (wr_conflict)
   );

   // Same-cycle write forwarding; the highest matching port overrides lower ones.
   always_comb begin
      w_fwd_hit = '0;
      for (int unsigned r = 0; r < READ_PORTS; r++) begin
         w_fwd_data[r] = '0;
         for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            if (wr_en[p] && (wr_addr[addr_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH] ==
                             rd_addr[addr_lsb(r, ADDR_WIDTH) +: ADDR_WIDTH])) begin
               w_fwd_hit[r]  = 1'b1;
               w_fwd_data[r] = wr_data[data_lsb(p, DATA_WIDTH) +: DATA_WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         r_rd_valid <= '0;
         r_fwd_hit  <= '0;
         for (int unsigned r = 0; r < READ_PORTS; r++) begin
            r_sel[r]      <= '0;
            r_fwd_data[r] <= '0;
            r_hold[r]     <= '0;
         end
      end else if (clk_en) begin
         r_rd_valid <= rd_en;
         for (int unsigned r = 0; r < READ_PORTS; r++) begin
            if (rd_en[r]) begin
               r_sel[r]      <= w_lookup[r*SEL_WIDTH +: SEL_WIDTH];
               r_fwd_hit[r]  <= w_fwd_hit[r];
               r_fwd_data[r] <= w_fwd_data[r];
            end
            if (r_rd_valid[r]) begin
               r_hold[r] <= w_rd_mux[r];
            end
         end
      end
   end

   // Result is combinational from stage-1 state; r_hold keeps the last valid result between reads.
   always_comb begin
      rd_data = '0;
      for (int unsigned r = 0; r < READ_PORTS; r++) begin
         w_rd_mux[r] = r_fwd_hit[r] ? r_fwd_data[r] :
                       bank_rd_data[bank_lsb(r, 32'(r_sel[r]), WRITE_PORTS, DATA_WIDTH) +: DATA_WIDTH];
         rd_data[data_lsb(r, DATA_WIDTH) +: DATA_WIDTH] = r_rd_valid[r] ? w_rd_mux[r] : r_hold[r];
      end
   end

   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_regfile_lvt_read_port.sv
// Bench: banks plus a flat register-file reference model; the read result must
// equal the latest value written to the address (write-first), whatever bank holds it.
module tb_regfile_lvt_read_port;

   localparam int DW = 64;
   localparam int RC = 64;
   localparam int AW = 6;
   localparam int WP = 4;
   localparam int RP = 8;
   localparam int SW = 2;

   logic                clk = 1'b0;
   logic                sync_rst;
   logic                clk_en;
   logic [WP-1:0]       wr_en;
   logic [AW*WP-1:0]    wr_addr;
   logic [DW*WP-1:0]    wr_data;
   logic [RP-1:0]       rd_en;
   logic [AW*RP-1:0]    rd_addr;
   logic [DW*WP*RP-1:0] bank_rd_data;
   logic [DW*RP-1:0]    rd_data;
   logic [RP-1:0]       rd_valid;
   logic                wr_conflict;

   always #5 clk = ~clk;

   regfile_lvt_read_port #(
      .DATA_WIDTH  (DW),
      .REG_COUNT   (RC),
      .ADDR_WIDTH  (AW),
      .WRITE_PORTS (WP),
      .READ_PORTS  (RP),
      .SEL_WIDTH   (SW)
   ) dut (
      .clk          (clk),
      .sync_rst     (sync_rst),
      .clk_en       (clk_en),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .bank_rd_data (bank_rd_data),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .wr_conflict  (wr_conflict)
   );

   logic [DW-1:0] mem      [WP][RC];
   logic [DW-1:0] flat     [RC];
   logic [DW-1:0] bank_out [RP][WP];
   logic [DW-1:0] exp_data [RP];
   logic          exp_valid[RP];
   logic          exp_conf;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int wa(input int p);
      return int'(wr_addr[p*AW +: AW]);
   endfunction

   function automatic int ra(input int r);
      return int'(rd_addr[r*AW +: AW]);
   endfunction

   function automatic logic [DW-1:0] rdat(input int r);
      return rd_data[r*DW +: DW];
   endfunction

   task automatic idle();
      sync_rst = 1'b0;
      clk_en   = 1'b1;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_en    = '0;
      rd_addr  = '0;
   endtask

   // One clock: advance the model for the inputs currently applied, drive banks, check outputs.
   task automatic step();
      @(posedge clk);
      #1;
      if (sync_rst) begin
         for (int r = 0; r < RP; r++) begin
            exp_valid[r] = 1'b0;
            exp_data[r]  = '0;
         end
         exp_conf = 1'b0;
         for (int a = 0; a < RC; a++) flat[a] = mem[0][a];
      end else if (clk_en) begin
         for (int r = 0; r < RP; r++)
            for (int b = 0; b < WP; b++)
               bank_out[r][b] = mem[b][ra(r)];
         exp_conf = 1'b0;
         for (int p = 0; p < WP; p++)
            for (int q = p + 1; q < WP; q++)
               if (wr_en[p] && wr_en[q] && wa(p) == wa(q)) exp_conf = 1'b1;
         for (int p = 0; p < WP; p++) begin
            if (wr_en[p]) begin
               mem[p][wa(p)] = wr_data[p*DW +: DW];
               flat[wa(p)]   = wr_data[p*DW +: DW];
            end
         end
         for (int r = 0; r < RP; r++) begin
            exp_valid[r] = rd_en[r];
            if (rd_en[r]) exp_data[r] = flat[ra(r)];
         end
      end
      for (int r = 0; r < RP; r++)
         for (int b = 0; b < WP; b++)
            bank_rd_data[(r*WP + b)*DW +: DW] = bank_out[r][b];
      #1;
      for (int r = 0; r < RP; r++) begin
         chk($sformatf("rd_valid[%0d]", r), {63'd0, rd_valid[r]}, {63'd0, exp_valid[r]});
         chk($sformatf("rd_data[%0d]", r), rdat(r), exp_data[r]);
      end
      chk("wr_conflict", {63'd0, wr_conflict}, {63'd0, exp_conf});
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, RC - 1)) : AW'($urandom_range(0, 7));
   endfunction

   task automatic rand_inputs(input bit allow_rst);
      sync_rst = allow_rst && ($urandom_range(0, 199) == 0);
      clk_en   = ($urandom_range(0, 9) != 0);
      wr_en    = sync_rst ? '0 : WP'($urandom);
      rd_en    = RP'($urandom);
      for (int p = 0; p < WP; p++) begin
         wr_addr[p*AW +: AW] = rand_addr();
         wr_data[p*DW +: DW] = {$urandom, $urandom};
      end
      for (int r = 0; r < RP; r++) rd_addr[r*AW +: AW] = rand_addr();
   endtask

   initial begin
      for (int b = 0; b < WP; b++)
         for (int a = 0; a < RC; a++)
            mem[b][a] = {$urandom, $urandom};
      for (int r = 0; r < RP; r++) begin
         for (int b = 0; b < WP; b++) bank_out[r][b] = '0;
         exp_data[r]  = '0;
         exp_valid[r] = 1'b0;
      end
      exp_conf     = 1'b0;
      bank_rd_data = '0;
      mem[0][5]    = 64'hAAAA;

      // Reset then read through bank 0
      idle();
      sync_rst = 1'b1;
      step();
      step();
      idle();
      rd_en[0] = 1'b1;
      rd_addr[0 +: AW] = 6'd5;
      step();
      chk("rst_read", rdat(0), 64'hAAAA);

      // Write on port 2, read on port 3 the next cycle
      idle();
      wr_en[2] = 1'b1;
      wr_addr[2*AW +: AW] = 6'd17;
      wr_data[2*DW +: DW] = 64'h1234;
      step();
      idle();
      rd_en[3] = 1'b1;
      rd_addr[3*AW +: AW] = 6'd17;
      step();
      chk("wr_then_rd", rdat(3), 64'h1234);

      // Same-cycle forward
      idle();
      wr_en[1] = 1'b1;
      wr_addr[1*AW +: AW] = 6'd9;
      wr_data[1*DW +: DW] = 64'hBEEF;
      rd_en[0] = 1'b1;
      rd_addr[0 +: AW] = 6'd9;
      step();
      chk("fwd", rdat(0), 64'hBEEF);

      // Collision on address 40
      idle();
      wr_en[0] = 1'b1;
      wr_en[3] = 1'b1;
      wr_addr[0 +: AW]    = 6'd40;
      wr_addr[3*AW +: AW] = 6'd40;
      wr_data[0 +: DW]    = 64'h11;
      wr_data[3*DW +: DW] = 64'h33;
      rd_en[0] = 1'b1;
      rd_addr[0 +: AW] = 6'd40;
      step();
      chk("coll_flag", {63'd0, wr_conflict}, 64'd1);
      chk("coll_fwd", rdat(0), 64'h33);
      idle();
      rd_en[1] = 1'b1;
      rd_addr[1*AW +: AW] = 6'd40;
      step();
      chk("coll_bank3", rdat(1), 64'h33);
      chk("coll_clear", {63'd0, wr_conflict}, 64'd0);

      // clk_en stall with ignored traffic
      idle();
      rd_en[2] = 1'b1;
      rd_addr[2*AW +: AW] = 6'd9;
      step();
      for (int k = 0; k < 3; k++) begin
         rand_inputs(1'b0);
         clk_en = 1'b0;
         step();
         chk("stall_valid", {63'd0, rd_valid[2]}, 64'd1);
         chk("stall_data", rdat(2), 64'hBEEF);
      end
      idle();
      rd_en[2] = 1'b1;
      rd_addr[2*AW +: AW] = 6'd9;
      step();
      chk("stall_resume", rdat(2), 64'hBEEF);

      // Reset mid-read, then every address must read bank 0
      idle();
      sync_rst = 1'b1;
      rd_en[4] = 1'b1;
      rd_addr[4*AW +: AW] = 6'd17;
      step();
      chk("rst_drop", {63'd0, rd_valid[4]}, 64'd0);
      for (int k = 0; k < RC / RP; k++) begin
         idle();
         rd_en = '1;
         for (int r = 0; r < RP; r++) rd_addr[r*AW +: AW] = AW'(k*RP + r);
         step();
         for (int r = 0; r < RP; r++) chk("lvt_bank0", rdat(r), mem[0][k*RP + r]);
      end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rand_inputs(1'b1);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
